board_score: RTL and testbench

BOARD_SCORE -- requirements
Module: board_score

---
 rtl/board_score_pkg.sv | 39 +++
 rtl/board_score_window_eval.sv | 33 +++
 rtl/board_score.sv | 97 +++++++++
 tb/tb_board_score.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/board_score_pkg.sv
// Shared geometry, cell encodings and scoring weights for the Connect-4 evaluator.
package board_score_pkg;

  localparam int unsigned ROWS    = 6;
  localparam int unsigned COLS    = 7;
  localparam int unsigned N_CELLS = ROWS * COLS;
  localparam int unsigned GRID_W  = 2 * N_CELLS;
  localparam int unsigned IDX_W   = 7;
  localparam int unsigned SCORE_W = 9;
  localparam int unsigned SUM_W   = 11;
  localparam int unsigned CONT_W  = 4;

  // Window counts per direction and their base offsets in the flat window index.
  localparam int unsigned N_HORZ  = ROWS * (COLS - 3);
  localparam int unsigned N_VERT  = (ROWS - 3) * COLS;
  localparam int unsigned N_DIAG  = (ROWS - 3) * (COLS - 3);
  localparam int unsigned N_WIN   = N_HORZ + N_VERT + 2 * N_DIAG;
  localparam int unsigned BASE_V  = N_HORZ;
  localparam int unsigned BASE_UR = N_HORZ + N_VERT;
  localparam int unsigned BASE_UL = N_HORZ + N_VERT + N_DIAG;

  localparam logic [1:0] CELL_AI  = 2'b10;
  localparam logic [1:0] CELL_OPP = 2'b01;

  localparam logic [SCORE_W-1:0] WIN_SCORE  = 9'd511;
  localparam logic [SCORE_W-1:0] LOSS_SCORE = 9'd0;

  localparam int NEUTRAL      = 256;
  localparam int W3           = 5;
  localparam int W2           = 2;
  localparam int CENTER_BONUS = 4;
  localparam int CENTER_COL   = 3;

  // Cell number of (row, col); its two grid bits are [2n+1:2n].
  function automatic int unsigned cell_idx(input int unsigned r, input int unsigned c);
    return (COLS - 1 - c) + COLS * r;
  endfunction

endpackage

// File: rtl/board_score_window_eval.sv
// Scores one four-cell window: win flags plus a signed threat contribution.
module window_eval
  import board_score_pkg::*;
(
  input  logic [1:0]              c0,
  input  logic [1:0]              c1,
  input  logic [1:0]              c2,
  input  logic [1:0]              c3,
  output logic                    ai_win,
  output logic                    opp_win,
  output logic signed [CONT_W-1:0] contrib
);

  logic [2:0] n_ai;
  logic [2:0] n_opp;

  // Count discs per colour; a mixed window contributes nothing.
  always_comb begin
    n_ai    = 3'(c0 == CELL_AI)  + 3'(c1 == CELL_AI)  + 3'(c2 == CELL_AI)  + 3'(c3 == CELL_AI);
    n_opp   = 3'(c0 == CELL_OPP) + 3'(c1 == CELL_OPP) + 3'(c2 == CELL_OPP) + 3'(c3 == CELL_OPP);
    ai_win  = (n_ai == 3'd4);
    opp_win = (n_opp == 3'd4);
    contrib = '0;
    if (n_opp == 3'd0) begin
      if (n_ai == 3'd3)      contrib = CONT_W'(W3);
      else if (n_ai == 3'd2) contrib = CONT_W'(W2);
    end else if (n_ai == 3'd0) begin
      if (n_opp == 3'd3)      contrib = -CONT_W'(W3);
      else if (n_opp == 3'd2) contrib = -CONT_W'(W2);
    end
  end

endmodule

// File: rtl/board_score.sv
// Registered Connect-4 board evaluation from the AI's point of view.
module board_score
  import board_score_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [GRID_W-1:0]   grid,
  input  logic [IDX_W-1:0]    ai,
  input  logic [IDX_W-1:0]    opponent,
  output logic [SCORE_W-1:0]  score
);

  localparam logic signed [SUM_W-1:0] MIN_SUM = 11'sd1;
  localparam logic signed [SUM_W-1:0] MAX_SUM = 11'sd510;

  logic [1:0]               cells [N_CELLS];
  logic [N_CELLS-1:0]       ai_hit;
  logic [N_CELLS-1:0]       opp_hit;
  logic [N_WIN-1:0]         ai_wins;
  logic [N_WIN-1:0]         opp_wins;
  logic signed [CONT_W-1:0] contribs [N_WIN];
  logic signed [SUM_W-1:0]  sum;
  logic [SCORE_W-1:0]       next_score;

  // Unpack cells and flag last-move hits on own discs in the centre column.
  for (genvar n = 0; n < N_CELLS; n++) begin : g_cell
    assign cells[n] = grid[2*n +: 2];
    if ((COLS - 1 - (n % COLS)) == CENTER_COL) begin : g_center
      assign ai_hit[n]  = (ai[IDX_W-1:1] == 6'(n))       && (cells[n] == CELL_AI);
      assign opp_hit[n] = (opponent[IDX_W-1:1] == 6'(n)) && (cells[n] == CELL_OPP);
    end else begin : g_edge
      assign ai_hit[n]  = 1'b0;
      assign opp_hit[n] = 1'b0;
    end
  end

  // Horizontal windows.
  for (genvar r = 0; r < ROWS; r++) begin : g_h_r
    for (genvar c = 0; c <= COLS - 4; c++) begin : g_h_c
      window_eval u_win (
        .c0(cells[cell_idx(r, c)]),   .c1(cells[cell_idx(r, c+1)]),
        .c2(cells[cell_idx(r, c+2)]), .c3(cells[cell_idx(r, c+3)]),
        .ai_win(ai_wins[r*(COLS-3)+c]), .opp_win(opp_wins[r*(COLS-3)+c]),
        .contrib(contribs[r*(COLS-3)+c]));
    end
  end

  // Vertical windows.
  for (genvar r = 0; r <= ROWS - 4; r++) begin : g_v_r
    for (genvar c = 0; c < COLS; c++) begin : g_v_c
      window_eval u_win (
        .c0(cells[cell_idx(r, c)]),   .c1(cells[cell_idx(r+1, c)]),
        .c2(cells[cell_idx(r+2, c)]), .c3(cells[cell_idx(r+3, c)]),
        .ai_win(ai_wins[BASE_V+r*COLS+c]), .opp_win(opp_wins[BASE_V+r*COLS+c]),
        .contrib(contribs[BASE_V+r*COLS+c]));
    end
  end

  // Diagonal windows rising to the right and to the left.
  for (genvar r = 0; r <= ROWS - 4; r++) begin : g_d_r
    for (genvar c = 0; c <= COLS - 4; c++) begin : g_d_c
      window_eval u_ur (
        .c0(cells[cell_idx(r, c)]),     .c1(cells[cell_idx(r+1, c+1)]),
        .c2(cells[cell_idx(r+2, c+2)]), .c3(cells[cell_idx(r+3, c+3)]),
        .ai_win(ai_wins[BASE_UR+r*(COLS-3)+c]), .opp_win(opp_wins[BASE_UR+r*(COLS-3)+c]),
        .contrib(contribs[BASE_UR+r*(COLS-3)+c]));
      window_eval u_ul (
        .c0(cells[cell_idx(r, c+3)]),   .c1(cells[cell_idx(r+1, c+2)]),
        .c2(cells[cell_idx(r+2, c+1)]), .c3(cells[cell_idx(r+3, c)]),
        .ai_win(ai_wins[BASE_UL+r*(COLS-3)+c]), .opp_win(opp_wins[BASE_UL+r*(COLS-3)+c]),
        .contrib(contribs[BASE_UL+r*(COLS-3)+c]));
    end
  end

  // Sum window contributions and centre bonuses, then resolve wins and clamp.
  always_comb begin
    sum = SUM_W'(NEUTRAL);
    for (int i = 0; i < N_WIN; i++) begin
      sum = sum + SUM_W'(contribs[i]);
    end
    if (|ai_hit)  sum = sum + SUM_W'(CENTER_BONUS);
    if (|opp_hit) sum = sum - SUM_W'(CENTER_BONUS);

    if (|opp_wins)          next_score = LOSS_SCORE;
    else if (|ai_wins)      next_score = WIN_SCORE;
    else if (sum < MIN_SUM) next_score = SCORE_W'(MIN_SUM);
    else if (sum > MAX_SUM) next_score = SCORE_W'(MAX_SUM);
    else                    next_score = SCORE_W'(sum);
  end

  // Output register; reset wins over evaluation.
  always_ff @(posedge clk) begin
    if (rst) score <= LOSS_SCORE;
    else     score <= next_score;
  end

endmodule

// File: tb/tb_board_score.sv
// Randomised check of board_score against a row/column board model.
module tb_board_score;

  logic        clk = 1'b0;
  logic        rst;
  logic [83:0] grid;
  logic [6:0]  ai;
  logic [6:0]  opponent;
  logic [8:0]  score;

  int errors = 0;
  int checks = 0;
  int exp_q  = 0;
  bit exp_v  = 1'b0;

  board_score dut (
    .clk(clk), .rst(rst), .grid(grid), .ai(ai), .opponent(opponent), .score(score));

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Board model: decode to +1/-1/0 per (row,col), walk every 4-long line.
  function automatic int model(input logic [83:0] g, input logic [6:0] a, input logic [6:0] o);
    int b [6][7];
    int dr [4] = '{0, 1, 1, 1};
    int dc [4] = '{1, 0, 1, -1};
    int sum = 256;
    bit aw = 0;
    bit ow = 0;
    int na, no, er, ec, x, n;
    logic [1:0] v;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++) begin
        v = g[7'(2*(6-c+7*r)) +: 2];
        b[r][c] = (v == 2'b10) ? 1 : (v == 2'b01) ? -1 : 0;
      end
    for (int d = 0; d < 4; d++)
      for (int r = 0; r < 6; r++)
        for (int c = 0; c < 7; c++) begin
          er = r + 3*dr[d];
          ec = c + 3*dc[d];
          if (er < 6 && ec >= 0 && ec < 7) begin
            na = 0; no = 0;
            for (int k = 0; k < 4; k++) begin
              x = b[r+k*dr[d]][c+k*dc[d]];
              if (x == 1) na++;
              if (x == -1) no++;
            end
            if (na == 4) aw = 1;
            if (no == 4) ow = 1;
            if (no == 0) sum += (na == 3) ? 5 : (na == 2) ? 2 : 0;
            if (na == 0) sum -= (no == 3) ? 5 : (no == 2) ? 2 : 0;
          end
        end
    if (a < 84) begin
      n = a / 2;
      if (n % 7 == 3 && b[n/7][3] == 1) sum += 4;
    end
    if (o < 84) begin
      n = o / 2;
      if (n % 7 == 3 && b[n/7][3] == -1) sum -= 4;
    end
    if (ow) return 0;
    if (aw) return 511;
    if (sum < 1) return 1;
    if (sum > 510) return 510;
    return sum;
  endfunction

  // Dense no-win pattern: every row except 3, every column except 3.
  function automatic logic [83:0] pattern_grid(input logic [1:0] col);
    logic [83:0] g = '0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++)
        if (r != 3 && c != 3) g[7'(2*(6-c+7*r)) +: 2] = col;
    return g;
  endfunction

  function automatic logic [83:0] rand_grid(input int pct);
    logic [83:0] g;
    for (int n = 0; n < 42; n++) begin
      if (int'($urandom_range(0, 99)) < pct) g[7'(2*n) +: 2] = $urandom_range(0, 1) ? 2'b10 : 2'b01;
      else                                   g[7'(2*n) +: 2] = $urandom_range(0, 1) ? 2'b00 : 2'b11;
    end
    return g;
  endfunction

  function automatic logic [6:0] rand_idx();
    case ($urandom_range(0, 2))
      0:       return 7'($urandom_range(0, 127));
      1:       return 7'(2*(3 + 7*$urandom_range(0, 5)) + $urandom_range(0, 1));
      default: return 7'($urandom_range(0, 1));
    endcase
  endfunction

  // Reference register: what score must hold after each edge.
  always @(posedge clk) begin
    exp_q <= rst ? 0 : model(grid, ai, opponent);
    exp_v <= 1'b1;
  end

  // Every-cycle comparison away from the active edge.
  always @(negedge clk) begin
    if (exp_v) check("score_vs_model", int'(score), exp_q);
  end

  task automatic apply(input string nm, input logic [83:0] g, input logic [6:0] a,
                       input logic [6:0] o, input int lit);
    grid = g; ai = a; opponent = o;
    @(posedge clk); #1;
    check(nm, int'(score), lit);
    check({nm, "_model"}, model(g, a, o), lit);
    @(negedge clk);
  endtask

  initial begin
    logic [83:0] g;
    rst = 1'b1; grid = '0; ai = 7'd1; opponent = 7'd0;
    repeat (2) @(negedge clk);
    check("reset", int'(score), 0);
    rst = 1'b0;

    apply("empty", '0, 7'd1, 7'd0, 256);
    g = '0; g[13:6] = 8'b10101010;
    apply("ai_row_win", g, 7'd7, 7'd0, 511);
    g[0] = 1'b1; g[14] = 1'b1; g[28] = 1'b1; g[42] = 1'b1;
    apply("opp_priority", g, 7'd7, 7'd0, 0);
    g = '0; g[7:6] = 2'b10;
    apply("center_ai", g, 7'd7, 7'd0, 260);
    apply("center_ai_even", g, 7'd6, 7'd0, 260);
    apply("center_sentinel", g, 7'd1, 7'd0, 256);
    apply("opp_idx_on_ai", g, 7'd1, 7'd7, 256);
    g = '0; g[13:10] = 4'b1010;
    apply("ai_pair", g, 7'd13, 7'd0, 258);
    g = '0; g[7:6] = 2'b01;
    apply("center_opp", g, 7'd1, 7'd6, 252);
    apply("center_opp_odd", g, 7'd1, 7'd7, 252);
    apply("opp_idx_out_range", g, 7'd1, 7'd127, 256);
    apply("clamp_low", pattern_grid(2'b01), 7'd1, 7'd0, 1);
    apply("clamp_high", pattern_grid(2'b10), 7'd1, 7'd0, 510);

    g = '0; g[7:6] = 2'b10;
    apply("pre_reset", g, 7'd7, 7'd0, 260);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_reset", int'(score), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_reset", int'(score), 260);
    @(negedge clk);

    for (int i = 0; i < 1500; i++) begin
      grid     = rand_grid(int'($urandom_range(5, 45)));
      ai       = rand_idx();
      opponent = rand_idx();
      rst      = ($urandom_range(0, 29) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
